pkt_slot_cache: RTL

//  Parametrised slot-based packet buffer between ingress gpp and the gda/ebm side. Stores each packet
//  in a free slot and advertises the next slot ID and free-slot count upstream. Replays a stored packet

---
 rtl/pkt_slot_cache_if.sv | 38 +++
 rtl/pkt_slot_cache.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pkt_slot_cache_if.sv
// Ingress/egress bundle of the slot cache.
// The master drives in_*, the slave drives out_*.
interface pkt_slot_cache_if #(
   parameter int DATA_W = 134,
   parameter int ID_W   = 8,
   parameter int CNT_W  = 6
);
   logic              in_pkt_data_wr;
   logic [DATA_W-1:0] in_pkt_data;
   logic              in_pkt_valid_wr;
   logic              in_pkt_valid;
   logic [ID_W-1:0]   out_pkt_ID;
   logic [CNT_W-1:0]  out_pkt_ID_count;
   logic              in_pkt_ID_wr;
   logic [ID_W-1:0]   in_pkt_ID;
   logic              in_pkt_ID_rel;
   logic              out_pkt_data_wr;
   logic [DATA_W-1:0] out_pkt_data;
   logic              out_pkt_valid_wr;
   logic              out_pkt_valid;
   logic              out_rd_busy;
   logic [15:0]       out_drop_cnt;
   logic              out_err;

   modport master (
      output in_pkt_data_wr, in_pkt_data, in_pkt_valid_wr, in_pkt_valid,
      output in_pkt_ID_wr, in_pkt_ID, in_pkt_ID_rel,
      input  out_pkt_ID, out_pkt_ID_count, out_pkt_data_wr, out_pkt_data,
      input  out_pkt_valid_wr, out_pkt_valid, out_rd_busy, out_drop_cnt, out_err
   );

   modport slave (
      input  in_pkt_data_wr, in_pkt_data, in_pkt_valid_wr, in_pkt_valid,
      input  in_pkt_ID_wr, in_pkt_ID, in_pkt_ID_rel,
      output out_pkt_ID, out_pkt_ID_count, out_pkt_data_wr, out_pkt_data,
      output out_pkt_valid_wr, out_pkt_valid, out_rd_busy, out_drop_cnt, out_err
   );
endinterface

// File: rtl/pkt_slot_cache.sv
// Slot-based packet buffer: free-ID FIFO, slot RAM, write and read engines.
// Packets are stored per slot, replayed on request, optionally released.
module pkt_slot_cache #(
   parameter int DATA_W     = 134,
   parameter int SLOT_NUM   = 32,
   parameter int SLOT_WORDS = 128,
   parameter int ID_W       = 8,
   parameter int CNT_W      = 6
) (
   input logic           clk,
   input logic           rst,
   pkt_slot_cache_if.slave bus
);
   localparam int AW = $clog2(SLOT_NUM);
   localparam int OW = $clog2(SLOT_WORDS);
   localparam logic [OW:0]      SW_L      = (OW+1)'(SLOT_WORDS);
   localparam logic [CNT_W-1:0] LAST_INIT = CNT_W'(SLOT_NUM-1);

   typedef enum logic [1:0] {W_IDLE, W_WR, W_DESC} wr_st_t;
   typedef enum logic [1:0] {R_IDLE, R_RD, R_DESC} rd_st_t;

   logic [DATA_W-1:0] mem_q  [SLOT_NUM*SLOT_WORDS];
   logic [ID_W-1:0]   free_q [SLOT_NUM];
   logic [OW:0]       len_q  [SLOT_NUM];

   logic [SLOT_NUM-1:0] commit_q;
   logic [CNT_W-1:0]    wptr_q, rptr_q, wptr_d, rptr_d, free_cnt;
   logic                init_q, init_d;
   logic [CNT_W-1:0]    init_cnt_q;

   wr_st_t          wst_q;
   logic            drop_q;
   logic [AW-1:0]   wid_q;
   logic [OW:0]     woff_q;
   logic            pend_q;
   logic [AW-1:0]   pend_id_q;

   rd_st_t          rd_q;
   logic [AW-1:0]   rid_q;
   logic            rrel_q;
   logic [OW:0]     roff_q, rlen_q;

   logic [ID_W-1:0]   id_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              odw_q, ovw_q, busy_q, err_q;
   logic [DATA_W-1:0] odata_q;
   logic [15:0]       drop_cnt_q;

   logic [1:0]        in_flag;
   logic              is_head, is_tail, can_pop, pop, push;
   logic [ID_W-1:0]   push_id, head_d;
   logic [OW:0]       wlen, close_len;
   logic              w_close, commit, disc, rel_push, hold;
   logic              w_en;
   logic [AW-1:0]     w_idx;
   logic [OW-1:0]     w_off;
   logic [AW-1:0]     rd_idx;
   logic              id_ok, rd_go, rd_bad, r_last;
   logic [AW+OW-1:0]  r_addr;
   logic [DATA_W-1:0] r_word;

   assign in_flag = bus.in_pkt_data[DATA_W-1 -: 2];

   always_comb begin
      is_head   = bus.in_pkt_data_wr && in_flag == 2'b01;
      is_tail   = bus.in_pkt_data_wr && in_flag == 2'b10;
      free_cnt  = wptr_q - rptr_q;
      can_pop   = !init_q && free_cnt != '0;
      pop       = wst_q == W_IDLE && is_head && can_pop;
      wlen      = woff_q + (OW+1)'(woff_q < SW_L);
      w_close   = (wst_q == W_WR && is_tail && bus.in_pkt_valid_wr) ||
                  (wst_q == W_DESC && bus.in_pkt_valid_wr);
      close_len = (wst_q == W_WR) ? wlen : woff_q;
      commit    = w_close && !drop_q && bus.in_pkt_valid;
      disc      = w_close && !drop_q && !bus.in_pkt_valid;
      rel_push  = rd_q == R_DESC && rrel_q;
      hold      = disc && (rel_push || pend_q);
      // read release wins; a colliding discard waits one cycle
      push      = 1'b1;
      push_id   = '0;
      if (init_q)        push_id = ID_W'(init_cnt_q);
      else if (rel_push) push_id = ID_W'(rid_q);
      else if (pend_q)   push_id = ID_W'(pend_id_q);
      else if (disc)     push_id = ID_W'(wid_q);
      else               push    = 1'b0;
      wptr_d = wptr_q + CNT_W'(push);
      rptr_d = rptr_q + CNT_W'(pop);
      init_d = init_q && init_cnt_q != LAST_INIT;
      head_d = (push && wptr_q[AW-1:0] == rptr_d[AW-1:0]) ?
               push_id : free_q[rptr_d[AW-1:0]];
      w_en  = pop || (wst_q == W_WR && bus.in_pkt_data_wr &&
                      !drop_q && woff_q < SW_L);
      w_idx = (wst_q == W_IDLE) ? id_q[AW-1:0] : wid_q;
      w_off = (wst_q == W_IDLE) ? '0 : woff_q[OW-1:0];
      rd_idx = bus.in_pkt_ID[AW-1:0];
      id_ok  = 32'(bus.in_pkt_ID) < SLOT_NUM;
      rd_go  = bus.in_pkt_ID_wr && rd_q == R_IDLE && id_ok && commit_q[rd_idx];
      rd_bad = bus.in_pkt_ID_wr && !rd_go;
      r_last = roff_q == rlen_q - (OW+1)'(1);
      r_addr = {rid_q, roff_q[OW-1:0]};
      r_word = mem_q[r_addr];
      if (r_last) r_word[DATA_W-1 -: 2] = 2'b10;
   end

   always_ff @(posedge clk) begin
      if (w_en)   mem_q[{w_idx, w_off}] <= bus.in_pkt_data;
      if (push)   free_q[wptr_q[AW-1:0]] <= push_id;
      if (commit) len_q[wid_q] <= close_len;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         commit_q   <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         init_q     <= 1'b1;
         init_cnt_q <= '0;
         wst_q      <= W_IDLE;
         drop_q     <= 1'b0;
         wid_q      <= '0;
         woff_q     <= '0;
         pend_q     <= 1'b0;
         pend_id_q  <= '0;
         rd_q       <= R_IDLE;
         rid_q      <= '0;
         rrel_q     <= 1'b0;
         roff_q     <= '0;
         rlen_q     <= '0;
         id_q       <= '0;
         cnt_q      <= '0;
         odw_q      <= 1'b0;
         odata_q    <= '0;
         ovw_q      <= 1'b0;
         busy_q     <= 1'b0;
         drop_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         init_q <= init_d;
         if (init_q) init_cnt_q <= init_cnt_q + CNT_W'(1);
         id_q  <= head_d;
         cnt_q <= init_d ? '0 : wptr_d - rptr_d;

         if (hold) begin
            pend_q    <= 1'b1;
            pend_id_q <= wid_q;
         end else if (pend_q && !rel_push) begin
            pend_q <= 1'b0;
         end

         if (commit)   commit_q[wid_q] <= 1'b1;
         if (rel_push) commit_q[rid_q] <= 1'b0;

         unique case (wst_q)
            W_IDLE: if (is_head) begin
               wid_q  <= id_q[AW-1:0];
               drop_q <= !can_pop;
               woff_q <= (OW+1)'(1);
               wst_q  <= W_WR;
               if (!can_pop && drop_cnt_q != 16'hFFFF)
                  drop_cnt_q <= drop_cnt_q + 16'd1;
            end
            W_WR: if (bus.in_pkt_data_wr) begin
               woff_q <= wlen;
               if (is_tail) wst_q <= bus.in_pkt_valid_wr ? W_IDLE : W_DESC;
            end
            W_DESC: if (bus.in_pkt_valid_wr) wst_q <= W_IDLE;
            default: wst_q <= W_IDLE;
         endcase

         unique case (rd_q)
            R_IDLE: if (rd_go) begin
               rid_q  <= rd_idx;
               rrel_q <= bus.in_pkt_ID_rel;
               rlen_q <= len_q[rd_idx];
               roff_q <= '0;
               rd_q   <= R_RD;
            end
            R_RD: begin
               roff_q <= roff_q + (OW+1)'(1);
               if (r_last) rd_q <= R_DESC;
            end
            R_DESC: rd_q <= R_IDLE;
            default: rd_q <= R_IDLE;
         endcase

         busy_q  <= (rd_q == R_IDLE) ? rd_go : (rd_q != R_DESC);
         odw_q   <= rd_q == R_RD;
         odata_q <= (rd_q == R_RD) ? r_word : '0;
         ovw_q   <= rd_q == R_DESC;
         if (rd_bad) err_q <= 1'b1;
      end
   end

   assign bus.out_pkt_ID       = id_q;
   assign bus.out_pkt_ID_count = cnt_q;
   assign bus.out_pkt_data_wr  = odw_q;
   assign bus.out_pkt_data     = odata_q;
   assign bus.out_pkt_valid_wr = ovw_q;
   assign bus.out_pkt_valid    = ovw_q;
   assign bus.out_rd_busy      = busy_q;
   assign bus.out_drop_cnt     = drop_cnt_q;
   assign bus.out_err          = err_q;
endmodule
